seq_shift_add_mult: RTL and testbench

- Parametrised iterative shift-and-add multiplier producing the full 2*WIDTH-bit product of two unsigned WIDTH-bit operands.
- Retires STEP multiplier bits per cycle.
- Uses valid/ready handshakes on input and output, so it can sit between operand staging and the modular-reduction datapath of the crypto core.
- Successor to the fixed-width 1024-bit multiplier: adds a configurable width and radix, an explicit start/done protocol, a full-width result and output backpressure.

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_mult_pp_gen.sv | 21 ++
 rtl/seq_shift_add_mult.sv | 121 ++++++++++++
 tb/tb_seq_shift_add_mult.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Number of RUN cycles for a full-length multiply.
  function automatic int unsigned cycle_count(input int unsigned width, input int unsigned step);
    if (step == 0) return 1;
    return width / step;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned step);
    return (width >= 2) && (step >= 1) && (step <= 8) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/seq_mult_pp_gen.sv
// Combinational STEP-bit partial product: mcand * digit as STEP shifted conditional adds.
module seq_mult_pp_gen
  import seq_mult_pkg::*;
#(
  parameter int unsigned PW   = 16,
  parameter int unsigned STEP = 1
) (
  input  logic [PW-1:0]   mcand,
  input  logic [STEP-1:0] digit,
  output logic [PW-1:0]   pp_c
);

  // Result is truncated to PW bits; the caller guarantees no true overflow.
  always_comb begin
    pp_c = '0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (digit[i]) pp_c = pp_c + (mcand << i);
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier with valid/ready handshakes, STEP bits per cycle.
// Optional macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned CYCLES = cycle_count(WIDTH, STEP);
  localparam int unsigned CNT_W  = $clog2(CYCLES) + 1;

  generate
    if (!params_ok(WIDTH, STEP)) begin : g_bad_params
      $error("seq_shift_add_mult: WIDTH must be >= 2, STEP in 1..8 and divide WIDTH");
    end
  endgenerate

  mult_state_e        state, state_nxt;
  logic [PW-1:0]      mcand;
  logic [WIDTH-1:0]   mplr;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;

  logic               load, step_en, finish;
  logic               last_c;
  logic [PW-1:0]      pp_c;
  logic [PW-1:0]      acc_sum;
  logic [WIDTH-1:0]   mplr_shr;

  seq_mult_pp_gen #(
    .PW   (PW),
    .STEP (STEP)
  ) u_pp_gen (
    .mcand (mcand),
    .digit (mplr[STEP-1:0]),
    .pp_c  (pp_c)
  );

  assign acc_sum  = acc + pp_c;
  assign mplr_shr = mplr >> STEP;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_c = (cnt == CNT_W'(CYCLES - 1)) || (mplr_shr == '0);
`else
  assign last_c = (cnt == CNT_W'(CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_en   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (last_c) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, accumulation and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (load) begin
        mcand <= PW'(a);
        mplr  <= b;
        acc   <= '0;
        cnt   <= '0;
      end else if (step_en) begin
        acc   <= acc_sum;
        mcand <= mcand << STEP;
        mplr  <= mplr_shr;
        cnt   <= cnt + CNT_W'(1);
      end
      if (finish) product <= acc_sum;
    end
  end

  // Handshake flags decode the state register; in_ready is also masked during reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed self-checking bench: two 8-bit instances (STEP=1 and STEP=2).
module tb_seq_shift_add_mult;

  logic        clk;
  logic        rst;
  logic        in_valid1, in_valid2;
  logic [7:0]  a, b;
  logic        out_ready;
  logic        ir1, ov1, busy1;
  logic        ir2, ov2, busy2;
  logic [15:0] p1, p2;

  int          sel;
  logic        cur_ir, cur_ov, cur_busy;
  logic [15:0] cur_p;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shift_add_mult #(.WIDTH(8), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .product(p1), .busy(busy1)
  );

  seq_shift_add_mult #(.WIDTH(8), .STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(ir2), .a(a), .b(b),
    .out_valid(ov2), .out_ready(out_ready), .product(p2), .busy(busy2)
  );

  assign cur_ir   = (sel == 2) ? ir2   : ir1;
  assign cur_ov   = (sel == 2) ? ov2   : ov1;
  assign cur_busy = (sel == 2) ? busy2 : busy1;
  assign cur_p    = (sel == 2) ? p2    : p1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s == 2) in_valid2 = v;
    else        in_valid1 = v;
  endtask

  // Expected RUN-cycle count for an 8-bit multiplier operand.
  function automatic int exp_lat(input logic [7:0] bv, input int step);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int bl = 0;
    int l;
    for (int i = 0; i < 8; i++) if (bv[i]) bl = i + 1;
    l = (bl + step - 1) / step;
    return (l < 1) ? 1 : l;
`else
    return 8 / step;
`endif
  endfunction

  task automatic do_op(input int s, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [15:0] exp_p, input int hold, input string tag);
    int lat;
    bit rdy_low;
    bit stable;
    @(negedge clk);
    sel = s; a = ai; b = bi; out_ready = 1'b0;
    set_valid(s, 1'b1);
    #1 check({tag, "_in_ready"}, 64'(cur_ir), 64'd1);
    @(posedge clk);
    #1;
    set_valid(s, 1'b0);
    a = ~ai; b = ~bi;
    lat = 0; rdy_low = 1'b1;
    while (!cur_ov && lat < 40) begin
      if (cur_ir) rdy_low = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat(bi, (s == 2) ? 2 : 1)));
    check({tag, "_product"}, 64'(cur_p), 64'(exp_p));
    check({tag, "_busy_run"}, 64'({cur_busy, rdy_low}), 64'b11);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      set_valid(s, 1'b1); a = 8'h5A; b = 8'h3C;
      @(posedge clk);
      #1 if (!cur_ov || cur_p !== exp_p || cur_ir) stable = 1'b0;
    end
    @(negedge clk);
    set_valid(s, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_release"}, 64'({cur_ov, cur_ir, cur_busy, stable}), 64'b0101);
    check({tag, "_held_product"}, 64'(cur_p), 64'(exp_p));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid1 = 1'b0; in_valid2 = 1'b0;
    a = '0; b = '0; out_ready = 1'b0; sel = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags1", 64'({ir1, ov1, busy1}), 64'b000);
    check("rst_flags2", 64'({ir2, ov2, busy2}), 64'b000);
    check("rst_products", 64'({p1, p2}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", 64'({ir1, ir2}), 64'b11);

    do_op(1, 8'd255, 8'd255, 16'hFE01, 0, "s1_max");
    do_op(1, 8'd0,   8'd200, 16'd0,    0, "s1_a0");
    do_op(1, 8'h12,  8'd5,   16'd90,   0, "s1_x5");
    do_op(1, 8'h80,  8'h80,  16'h4000, 0, "s1_msb");
    do_op(1, 8'd200, 8'd0,   16'd0,    0, "s1_b0");
    do_op(1, 8'd1,   8'd1,   16'd1,    0, "s1_one");
    do_op(2, 8'd13,  8'd11,  16'd143,  0, "s2_13x11");
    do_op(2, 8'd0,   8'd200, 16'd0,    0, "s2_a0");
    do_op(2, 8'd255, 8'd255, 16'hFE01, 0, "s2_max");
    do_op(2, 8'd170, 8'd3,   16'd510,  0, "s2_170x3");
    do_op(1, 8'd37,  8'd19,  16'd703,  5, "s1_bp");
    do_op(2, 8'd99,  8'd77,  16'd7623, 5, "s2_bp");

    // Abandon a 7*9 multiply once cnt has reached 3.
    @(negedge clk);
    sel = 1; a = 8'd7; b = 8'd9;
    set_valid(1, 1'b1);
    @(posedge clk);
    #1 set_valid(1, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("midrun_busy", 64'({busy1, ov1}), 64'b10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrun_rst_flags", 64'({ir1, ov1, busy1}), 64'b100);
    check("midrun_rst_product", 64'(p1), 64'd0);
    do_op(1, 8'd3, 8'd4, 16'd12, 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
